// File: rtl/mux4x1_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux4x1_scan_ctrl
//
// Sequencer that walks the select lines of a 4:1 data-flow mux across the
// enabled channels and snapshots the mux output y for each channel into a
// 4-bit sample register. Supports single-shot (start) and continuous (cont)
// scans, a per-channel enable mask latched at scan start, and a programmable
// per-channel dwell time.
//
// Parameters:
//   DWELL    cycles each channel's select is held before y is captured (1..255)
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    single-cycle scan request, honoured only while idle
//   cont     continuous mode: an idle controller restarts a scan on its own
//   chan_en  channel enable mask, bit k enables mux channel k
//   y        mux output (combinational from the mux data and s1/s0)
//   s1, s0   registered mux selects; channel k is driven as {s1,s0} = ~k
//   sample   snapshot, sample[k] holds y captured while channel k was selected
//   busy     high while a scan is dwelling on channels
//   done     one-cycle pulse in the cycle after the final capture
// -----------------------------------------------------------------------------
module mux4x1_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic [3:0] chan_en,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic [3:0] sample,
  output logic       busy,
  output logic       done
);

  localparam int               CNT_W    = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Lowest set bit of a non-empty mask (returns 0 for an empty mask).
  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] ch;
    ch = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      ch = m[k] ? 2'(k) : ch;
    end
    return ch;
  endfunction

  // Next set bit strictly above cur, packed as {found, channel}.
  function automatic logic [2:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      r = (m[k] && (k > int'(cur))) ? {1'b1, 2'(k)} : r;
    end
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       cur_ch_r;
  logic [1:0]       sel_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       mask_r;
  logic [3:0]       sample_r;
  logic             busy_r;
  logic             done_r;

  logic [1:0]       first_s;
  logic [2:0]       nxt_s;
  logic             last_s;

  // Channel lookahead and end-of-dwell detection.
  always_comb begin
    first_s = lowest_ch(chan_en);
    nxt_s   = next_ch(mask_r, cur_ch_r);
    last_s  = (cnt_r == CNT_LAST);
  end

  // Scan sequencer: state, channel pointer, dwell counter and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cur_ch_r <= 2'd0;
      sel_r    <= 2'b11;
      cnt_r    <= CNT_ZERO;
      mask_r   <= 4'b0000;
      sample_r <= 4'b0000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start || cont) begin
            mask_r <= chan_en;
            if (chan_en != 4'b0000) begin
              cur_ch_r <= first_s;
              sel_r    <= ~first_s;
              cnt_r    <= CNT_ZERO;
              busy_r   <= 1'b1;
              state_r  <= ST_DWELL;
            end else begin
              // Nothing to scan: still complete the handshake with a done pulse.
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (last_s) begin
            // y reflects the select held for the whole dwell; capture it now.
            sample_r[cur_ch_r] <= y;
            cnt_r              <= CNT_ZERO;
            if (nxt_s[2]) begin
              cur_ch_r <= nxt_s[1:0];
              sel_r    <= ~nxt_s[1:0];
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DONE: begin
          // Selects keep the last channel until the next scan begins.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s1     = sel_r[1];
  assign s0     = sel_r[0];
  assign sample = sample_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_mux4x1_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux4x1_scan_ctrl
//
// Directed bench for mux4x1_scan_ctrl. A behavioural 4:1 mux closes the loop
// from s1/s0 back to y. A timeline model (cycles since scan start, list of
// enabled channels) predicts selects, sample, busy and done, and every cycle
// the DUT is compared against it; literal expectations pin key results.
// -----------------------------------------------------------------------------
module tb_mux4x1_scan_ctrl;

  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [3:0] chan_en;
  logic [3:0] i_vec;
  logic       y;
  logic       s1;
  logic       s0;
  logic [3:0] sample;
  logic       busy;
  logic       done;
  logic [1:0] sel_idx;

  int n_tests = 0;
  int n_fail  = 0;

  // Timeline model state.
  int         m_phase;      // 0 idle, 1 scanning, 2 completion cycle
  int         m_t;
  int         m_list [4];
  int         m_n;
  logic [1:0] m_ch;
  logic [3:0] m_sample;
  logic       m_busy;
  logic       m_done;
  logic       m_valid = 1'b0;

  // Observation helpers.
  logic [1:0] sel_log [$];
  int         busy_cnt;
  int         done_cnt;

  always #5 clk = ~clk;

  // The mux: channel k is selected when {s1,s0} == ~k.
  assign sel_idx = ~{s1, s0};
  assign y       = i_vec[sel_idx];

  mux4x1_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cont    (cont),
    .chan_en (chan_en),
    .y       (y),
    .s1      (s1),
    .s0      (s0),
    .sample  (sample),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    int idx;
    if (rst) begin
      m_phase  = 0;
      m_ch     = 2'd0;
      m_sample = 4'b0000;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_valid  = 1'b1;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: begin
          if (start || cont) begin
            m_n = 0;
            for (int k = 0; k < 4; k++) begin
              if (chan_en[k]) begin
                m_list[m_n] = k;
                m_n++;
              end
            end
            if (m_n > 0) begin
              m_phase = 1;
              m_t     = 0;
              m_ch    = 2'(m_list[0]);
              m_busy  = 1'b1;
            end else begin
              m_phase = 2;
              m_done  = 1'b1;
            end
          end
        end
        1: begin
          m_t++;
          if (m_t % DWELL == 0) begin
            idx = m_t / DWELL;
            m_sample[m_list[idx-1]] = i_vec[m_list[idx-1]];
            if (idx == m_n) begin
              m_busy  = 1'b0;
              m_done  = 1'b1;
              m_phase = 2;
            end else begin
              m_ch = 2'(m_list[idx]);
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: update the model at the edge, then compare once outputs settle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    sel_log.push_back({s1, s0});
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (m_valid) begin
      check("sel",    {6'd0, s1, s0}, {6'd0, ~m_ch});
      check("sample", {4'd0, sample}, {4'd0, m_sample});
      check("busy",   {7'd0, busy},   {7'd0, m_busy});
      check("done",   {7'd0, done},   {7'd0, m_done});
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    cont    = 1'b0;
    chan_en = 4'b0000;
    i_vec   = 4'b0000;

    // Reset for two cycles.
    run(2);
    check("rst_sel",    {6'd0, s1, s0}, 8'b0000_0011);
    check("rst_sample", {4'd0, sample}, 8'b0000_0000);
    check("rst_busy",   {7'd0, busy},   8'd0);
    check("rst_done",   {7'd0, done},   8'd0);
    rst = 1'b0;
    run(1);

    // Full scan, static i=1010.
    i_vec    = 4'b1010;
    chan_en  = 4'b1111;
    start    = 1'b1;
    sel_log.delete();
    busy_cnt = 0;
    done_cnt = 0;
    cycle();                       // E0
    start = 1'b0;
    run(7);                        // E1..E7
    check("full_sel_seq",
          {sel_log[0], sel_log[2], sel_log[4], sel_log[6]}, 8'b11_10_01_00);
    check("full_sel_hold",
          {sel_log[1], sel_log[3], sel_log[5], sel_log[7]}, 8'b11_10_01_00);
    cycle();                       // E8: final capture
    check("full_sample", {4'd0, sample}, 8'b0000_1010);
    check("full_done",   {7'd0, done},   8'd1);
    check("full_busy_cycles", 8'(busy_cnt), 8'd8);
    run(2);
    check("full_done_once", 8'(done_cnt), 8'd1);

    // Preload sample to 1111, then sparse mask 0101 with i=0000.
    i_vec = 4'b1111;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(10);
    check("pre_sample", {4'd0, sample}, 8'b0000_1111);
    i_vec   = 4'b0000;
    chan_en = 4'b0101;
    start   = 1'b1;
    sel_log.delete();
    cycle();                       // E0
    start = 1'b0;
    run(3);                        // E1..E3
    check("sparse_sel_seq",
          {sel_log[0], sel_log[1], sel_log[2], sel_log[3]}, 8'b11_11_01_01);
    cycle();                       // E4
    check("sparse_done",   {7'd0, done},   8'd1);
    check("sparse_sample", {4'd0, sample}, 8'b0000_1010);
    run(2);

    // Empty mask: no busy, done one cycle later, sample unchanged.
    chan_en  = 4'b0000;
    start    = 1'b1;
    busy_cnt = 0;
    cycle();
    start = 1'b0;
    check("empty_done",   {7'd0, done},   8'd1);
    check("empty_busy",   {7'd0, busy},   8'd0);
    check("empty_sample", {4'd0, sample}, 8'b0000_1010);
    cycle();
    check("empty_done_end", {7'd0, done}, 8'd0);
    check("empty_busy_cycles", 8'(busy_cnt), 8'd0);
    run(1);

    // Start re-asserted mid-scan is ignored.
    i_vec    = 4'b0110;
    chan_en  = 4'b1111;
    start    = 1'b1;
    done_cnt = 0;
    cycle();
    start = 1'b0;
    run(3);
    start   = 1'b1;
    chan_en = 4'b0001;             // mid-scan mask change must be ignored
    cycle();
    start = 1'b0;
    run(12);
    check("ignored_start_done_cnt", 8'(done_cnt), 8'd1);
    check("ignored_start_sample", {4'd0, sample}, 8'b0000_0110);

    // Continuous mode, i changes 1010 -> 0101 during the first scan.
    i_vec    = 4'b1010;
    chan_en  = 4'b1111;
    cont     = 1'b1;
    done_cnt = 0;
    run(3);                        // E0..E2
    i_vec = 4'b0101;
    run(6);                        // E3..E8
    check("cont_first_sample", {4'd0, sample}, 8'b0000_0100);
    run(10);                       // E9..E18
    check("cont_second_sample", {4'd0, sample}, 8'b0000_0101);
    check("cont_second_done", {7'd0, done}, 8'd1);
    cont = 1'b0;
    run(2);
    check("cont_idle_busy", {7'd0, busy}, 8'd0);
    check("cont_done_cnt", 8'(done_cnt), 8'd2);

    // Reset during the third busy cycle aborts the scan.
    i_vec   = 4'b1111;
    chan_en = 4'b1111;
    start   = 1'b1;
    cycle();                       // busy cycle 1
    start = 1'b0;
    run(2);                        // busy cycles 2, 3
    rst = 1'b1;
    cycle();
    check("abort_sel",    {6'd0, s1, s0}, 8'b0000_0011);
    check("abort_busy",   {7'd0, busy},   8'd0);
    check("abort_sample", {4'd0, sample}, 8'b0000_0000);
    rst      = 1'b0;
    done_cnt = 0;
    run(12);
    check("abort_no_done", 8'(done_cnt), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
